// File: rtl/shared_pkg.sv
// Shared FIFO definitions: default geometry and the per-cycle status bundle.
// The scoreboard and coverage packages import this package as well.
package shared_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    // Per-cycle status reported one cycle after the request that caused it.
    typedef struct packed {
        logic wr_ack;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH register array with one synchronous write
// port and one registered read port. The array itself is never cleared;
// only the read register returns to zero on reset.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Read register next value: load the addressed word on a read, else hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array write; no reset so the array maps onto plain registers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= {WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointer, occupancy count, flag and status logic around
// the fifo_mem storage. Flags decode the registered count only, and every
// other output is a flop, so no input reaches an output combinationally.
module sync_fifo
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] LAST_PTR_C  = AW'(FIFO_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE_C   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO_C  = CW'(1'b0);
    localparam logic [CW-1:0] CNT_FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AFULL_C = CW'(FIFO_DEPTH - 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    fifo_status_t  status_q, status_d;

    logic wr_acc_s;
    logic rd_acc_s;
    logic mem_we_s;
    logic mem_re_s;

    // Flags are a pure decode of the registered count.
    assign full        = (count_q == CNT_FULL_C);
    assign empty       = (count_q == CNT_ZERO_C);
    assign almostfull  = (count_q == CNT_AFULL_C);
    assign almostempty = (count_q == CNT_ONE_C);

    // Accept decisions and next-state for pointers, count and status.
    always_comb begin
        wr_acc_s = wr_en && !full;
        rd_acc_s = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        status_d = fifo_status_t'(3'b000);

        if (wr_acc_s) begin
            if (wr_ptr_q == LAST_PTR_C) begin
                wr_ptr_d = {AW{1'b0}};
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_ONE_C;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            if (rd_ptr_q == LAST_PTR_C) begin
                rd_ptr_d = {AW{1'b0}};
            end else begin
                rd_ptr_d = rd_ptr_q + PTR_ONE_C;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase

        status_d.wr_ack    = wr_acc_s;
        status_d.overflow  = wr_en && full;
        status_d.underflow = rd_en && empty;
    end

    // Storage strobes are suppressed in a reset cycle so requests are ignored.
    always_comb begin
        mem_we_s = 1'b0;
        mem_re_s = 1'b0;
        if (rst_n) begin
            mem_we_s = wr_acc_s;
            mem_re_s = rd_acc_s;
        end else begin
            mem_we_s = 1'b0;
            mem_re_s = 1'b0;
        end
    end

    // Pointer, count and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            status_q <= fifo_status_t'(3'b000);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            status_q <= status_d;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we_s),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (mem_re_s),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign wr_ack    = status_q.wr_ack;
    assign overflow  = status_q.overflow;
    assign underflow = status_q.underflow;

endmodule
